// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART host-port round-robin arbiter.
package uart_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } arb_state_e;

  localparam logic REG_SEL_CTRL = 1'b0;
  localparam logic REG_SEL_FIFO = 1'b1;

  localparam int N_REQ_DEF    = 4;
  localparam int DW_DEF       = 32;
  localparam int LOCK_MAX_DEF = 16;

endpackage

// File: rtl/uart_host_arbiter_rr_pick.sv
// Combinational round-robin picker: the first requester at or after ptr wins.
module rr_pick #(
  parameter int N  = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  onehot,
  output logic [PW-1:0] idx,
  output logic          valid
);

  logic [PW-1:0] k;

  // Walk the ring backwards so the candidate closest to ptr overwrites the rest.
  always_comb begin
    onehot = '0;
    idx    = '0;
    valid  = 1'b0;
    k      = '0;
    for (int i = N - 1; i >= 0; i--) begin
      k = PW'((int'(ptr) + i) % N);
      if (req[k]) begin
        idx   = k;
        valid = 1'b1;
      end
    end
    if (valid) onehot[idx] = 1'b1;
  end

endmodule

// File: rtl/uart_host_arbiter.sv
// Round-robin arbiter sharing one UART agent register port among N_REQ requesters.
// Optional bus lock feature enabled by defining UART_ARB_LOCK_EN.
//   state  | meaning
//   IDLE   | pick a winner and latch its command
//   ACCESS | drive the agent port, write strobe for writes
//   DONE   | capture read data, ack the winner, advance ptr
module uart_host_arbiter
  import uart_arb_pkg::*;
#(
  parameter int N_REQ    = N_REQ_DEF,
  parameter int DW       = DW_DEF,
  parameter int LOCK_MAX = LOCK_MAX_DEF
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic [N_REQ-1:0]    req_i,
  input  logic [N_REQ-1:0]    we_i,
  input  logic [N_REQ-1:0]    sel_i,
  input  logic [N_REQ*DW-1:0] wdata_i,
`ifdef UART_ARB_LOCK_EN
  input  logic [N_REQ-1:0]    lock_i,
`endif
  output logic [N_REQ-1:0]    gnt_o,
  output logic [N_REQ-1:0]    ack_o,
  output logic [DW-1:0]       rdata_o,
  output logic                reg_sel_o,
  output logic                wr_o,
  output logic [DW-1:0]       data_o,
  input  logic [DW-1:0]       data_i
);

  localparam int PW = $clog2(N_REQ);

  if (N_REQ < 2 || N_REQ > 8 || LOCK_MAX < 1) begin : g_bad_params
    $error("uart_host_arbiter: N_REQ must be 2..8 and LOCK_MAX at least 1");
  end

  arb_state_e        state, state_nxt;
  logic [PW-1:0]     ptr, win_idx, pick_idx, ptr_inc;
  logic [N_REQ-1:0]  pick_oh, win_oh;
  logic              pick_valid;
  logic              we_q, sel_q;
  logic [DW-1:0]     wdata_q, rdata_q;

`ifdef UART_ARB_LOCK_EN
  localparam int LW = (LOCK_MAX > 1) ? $clog2(LOCK_MAX) : 1;
  logic [LW-1:0] lock_cnt;
`endif

  rr_pick #(.N(N_REQ), .PW(PW)) u_pick (
    .req    (req_i),
    .ptr    (ptr),
    .onehot (pick_oh),
    .idx    (pick_idx),
    .valid  (pick_valid)
  );

  assign ptr_inc = (int'(win_idx) == N_REQ - 1) ? '0 : win_idx + 1'b1;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pick_valid) state_nxt = ACCESS;
      ACCESS:  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      ptr      <= '0;
      win_idx  <= '0;
      win_oh   <= '0;
      we_q     <= 1'b0;
      sel_q    <= REG_SEL_CTRL;
      wdata_q  <= '0;
      rdata_q  <= '0;
`ifdef UART_ARB_LOCK_EN
      lock_cnt <= '0;
`endif
    end else begin
      case (state)
        IDLE: if (pick_valid) begin
          win_idx <= pick_idx;
          win_oh  <= pick_oh;
          we_q    <= we_i[pick_idx];
          sel_q   <= sel_i[pick_idx];
          wdata_q <= wdata_i[int'(pick_idx)*DW +: DW];
        end
        DONE: begin
          if (!we_q) rdata_q <= data_i;
`ifdef UART_ARB_LOCK_EN
          // A locked winner keeps the pointer so it wins again, up to LOCK_MAX grants in a row.
          if (lock_i[win_idx] && int'(lock_cnt) < LOCK_MAX - 1) begin
            lock_cnt <= lock_cnt + 1'b1;
          end else begin
            lock_cnt <= '0;
            ptr      <= ptr_inc;
          end
`else
          ptr <= ptr_inc;
`endif
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    gnt_o     = (state != IDLE) ? win_oh : '0;
    ack_o     = (state == DONE) ? win_oh : '0;
    wr_o      = (state == ACCESS) && we_q;
    reg_sel_o = sel_q;
    data_o    = wdata_q;
    rdata_o   = (state == DONE && !we_q) ? data_i : rdata_q;
  end

endmodule

// File: tb/tb_uart_host_arbiter.sv
// Self-checking bench for uart_host_arbiter against a transaction-level round-robin model.
module tb_uart_host_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int LM = 3;

  logic            Clk, Rst_n;
  logic [N-1:0]    req_i, we_i, sel_i, lock_i;
  logic [N*DW-1:0] wdata_i;
  logic [N-1:0]    gnt_o, ack_o;
  logic [DW-1:0]   rdata_o, data_o, data_i;
  logic            reg_sel_o, wr_o;
  logic [DW-1:0]   rd_ctrl, rd_fifo;

  int n_tests = 0;
  int n_fail  = 0;

  int            m_ptr;
  int            m_lcnt;
  logic [DW-1:0] m_rdata;

  assign data_i = reg_sel_o ? rd_fifo : rd_ctrl;

  uart_host_arbiter #(.N_REQ(N), .DW(DW), .LOCK_MAX(LM)) dut (
    .Clk       (Clk),
    .Rst_n     (Rst_n),
    .req_i     (req_i),
    .we_i      (we_i),
    .sel_i     (sel_i),
    .wdata_i   (wdata_i),
`ifdef UART_ARB_LOCK_EN
    .lock_i    (lock_i),
`endif
    .gnt_o     (gnt_o),
    .ack_o     (ack_o),
    .rdata_o   (rdata_o),
    .reg_sel_o (reg_sel_o),
    .wr_o      (wr_o),
    .data_o    (data_o),
    .data_i    (data_i)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic int model_pick(input logic [N-1:0] r);
    for (int i = 0; i < N; i++) begin
      if (r[(m_ptr + i) % N]) return (m_ptr + i) % N;
    end
    return -1;
  endfunction

  function automatic void model_done(input int w, input logic lk);
`ifdef UART_ARB_LOCK_EN
    if (lk && m_lcnt < LM - 1) begin
      m_lcnt++;
    end else begin
      m_lcnt = 0;
      m_ptr  = (w + 1) % N;
    end
`else
    if (lk === 1'bx) m_lcnt = 0;
    m_ptr = (w + 1) % N;
`endif
  endfunction

  function automatic logic [N-1:0] oh(input int w);
    logic [N-1:0] v;
    v = '0;
    v[w] = 1'b1;
    return v;
  endfunction

  task automatic do_reset();
    Rst_n = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
    Rst_n   = 1'b1;
    m_ptr   = 0;
    m_lcnt  = 0;
    m_rdata = '0;
  endtask

  task automatic clear_inputs();
    req_i = '0; we_i = '0; sel_i = '0; lock_i = '0; wdata_i = '0;
    rd_ctrl = '0; rd_fifo = '0;
  endtask

  task automatic test_reset();
    clear_inputs();
    Rst_n = 1'b0;
    #3;
    n_tests++; if (gnt_o !== '0)     begin n_fail++; $display("FAIL reset_gnt got %b exp 0", gnt_o); end
    n_tests++; if (ack_o !== '0)     begin n_fail++; $display("FAIL reset_ack got %b exp 0", ack_o); end
    n_tests++; if (wr_o !== 1'b0)    begin n_fail++; $display("FAIL reset_wr got %b exp 0", wr_o); end
    n_tests++; if (rdata_o !== '0)   begin n_fail++; $display("FAIL reset_rdata got %h exp 0", rdata_o); end
    n_tests++; if (reg_sel_o !== 1'b0) begin n_fail++; $display("FAIL reset_sel got %b exp 0", reg_sel_o); end
    n_tests++; if (data_o !== '0)    begin n_fail++; $display("FAIL reset_data got %h exp 0", data_o); end
    do_reset();
  endtask

  task automatic test_single_write();
    req_i = 4'b0001; we_i = 4'b0001; sel_i = 4'b0000;
    wdata_i[0 +: DW] = 32'h0000_00A5;
    @(negedge Clk);
    n_tests++; if (wr_o !== 1'b1)    begin n_fail++; $display("FAIL wr_strobe got %b exp 1", wr_o); end
    n_tests++; if (data_o !== 32'hA5) begin n_fail++; $display("FAIL wr_data got %h exp a5", data_o); end
    n_tests++; if (reg_sel_o !== 1'b0) begin n_fail++; $display("FAIL wr_sel got %b exp 0", reg_sel_o); end
    n_tests++; if (gnt_o !== 4'b0001) begin n_fail++; $display("FAIL wr_gnt got %b exp 0001", gnt_o); end
    n_tests++; if (ack_o !== 4'b0000) begin n_fail++; $display("FAIL wr_early_ack got %b exp 0000", ack_o); end
    @(negedge Clk);
    n_tests++; if (ack_o !== 4'b0001) begin n_fail++; $display("FAIL wr_ack got %b exp 0001", ack_o); end
    n_tests++; if (wr_o !== 1'b0)    begin n_fail++; $display("FAIL wr_done_wr got %b exp 0", wr_o); end
    model_done(0, lock_i[0]);
    req_i = '0;
    @(negedge Clk);
    n_tests++; if (gnt_o !== '0 || wr_o !== 1'b0) begin n_fail++; $display("FAIL wr_idle gnt %b wr %b exp 0 0", gnt_o, wr_o); end
  endtask

  task automatic test_read();
    bit saw_wr;
    saw_wr = 0;
    req_i = 4'b0100; we_i = 4'b0000; sel_i = 4'b0100;
    rd_fifo = 32'h0000_0042; rd_ctrl = 32'hDEAD_BEEF;
    @(negedge Clk);
    if (wr_o !== 1'b0) saw_wr = 1;
    n_tests++; if (gnt_o !== 4'b0100)  begin n_fail++; $display("FAIL rd_gnt got %b exp 0100", gnt_o); end
    n_tests++; if (reg_sel_o !== 1'b1) begin n_fail++; $display("FAIL rd_sel got %b exp 1", reg_sel_o); end
    @(negedge Clk);
    if (wr_o !== 1'b0) saw_wr = 1;
    n_tests++; if (ack_o !== 4'b0100)  begin n_fail++; $display("FAIL rd_ack got %b exp 0100", ack_o); end
    n_tests++; if (rdata_o !== 32'h42) begin n_fail++; $display("FAIL rd_data got %h exp 42", rdata_o); end
    model_done(2, lock_i[2]);
    m_rdata = 32'h42;
    req_i = '0;
    @(negedge Clk);
    if (wr_o !== 1'b0) saw_wr = 1;
    n_tests++; if (saw_wr !== 1'b0) begin n_fail++; $display("FAIL rd_no_wr got %b exp 0", saw_wr); end
    n_tests++; if (rdata_o !== 32'h42) begin n_fail++; $display("FAIL rd_hold got %h exp 42", rdata_o); end
  endtask

  task automatic test_contention();
    int w;
    clear_inputs();
    req_i = 4'b1111;
    do_reset();
    for (int t = 0; t < 5; t++) begin
      w = model_pick(req_i);
      @(negedge Clk);
      n_tests++; if (gnt_o !== oh(w)) begin n_fail++; $display("FAIL cont_gnt txn %0d got %b exp %b", t, gnt_o, oh(w)); end
      @(negedge Clk);
      n_tests++; if (ack_o !== oh(w)) begin n_fail++; $display("FAIL cont_ack txn %0d got %b exp %b", t, ack_o, oh(w)); end
      model_done(w, lock_i[w]);
      @(negedge Clk);
      n_tests++; if (gnt_o !== '0) begin n_fail++; $display("FAIL cont_idle txn %0d got %b exp 0", t, gnt_o); end
    end
    req_i = '0;
  endtask

  task automatic test_reset_mid_access();
    req_i = 4'b0010; we_i = 4'b0010; wdata_i[DW +: DW] = $urandom;
    @(negedge Clk);
    n_tests++; if (wr_o !== 1'b1) begin n_fail++; $display("FAIL mid_wr_pre got %b exp 1", wr_o); end
    #2 Rst_n = 1'b0;
    #1;
    n_tests++; if (wr_o !== 1'b0)  begin n_fail++; $display("FAIL mid_wr_drop got %b exp 0", wr_o); end
    n_tests++; if (ack_o !== '0)   begin n_fail++; $display("FAIL mid_no_ack got %b exp 0", ack_o); end
    n_tests++; if (gnt_o !== '0)   begin n_fail++; $display("FAIL mid_gnt got %b exp 0", gnt_o); end
    req_i = 4'b1111; we_i = '0;
    @(negedge Clk);
    n_tests++; if (ack_o !== '0)   begin n_fail++; $display("FAIL mid_no_ack_held got %b exp 0", ack_o); end
    Rst_n = 1'b1; m_ptr = 0; m_lcnt = 0; m_rdata = '0;
    @(negedge Clk);
    n_tests++; if (gnt_o !== 4'b0001) begin n_fail++; $display("FAIL mid_ptr0 got %b exp 0001", gnt_o); end
    @(negedge Clk);
    model_done(0, lock_i[0]);
    req_i = '0;
    @(negedge Clk);
  endtask

  task automatic test_withdrawal();
    bit seen;
    seen = 0;
    req_i = 4'b0001; we_i = 4'b0001; sel_i = '0;
    @(negedge Clk);
    req_i = 4'b0011;
    @(negedge Clk);
    n_tests++; if (ack_o !== 4'b0001) begin n_fail++; $display("FAIL wd_ack0 got %b exp 0001", ack_o); end
    model_done(0, lock_i[0]);
    req_i = '0;
    for (int c = 0; c < 8; c++) begin
      @(negedge Clk);
      if (gnt_o[1] !== 1'b0 || ack_o[1] !== 1'b0) seen = 1;
    end
    n_tests++; if (seen !== 1'b0) begin n_fail++; $display("FAIL wd_skip req1 served got %b exp 0", seen); end
  endtask

  task automatic test_random();
    int w;
    logic exp_we, exp_sel, lk;
    logic [DW-1:0] exp_wd, exp_rd;
    for (int it = 0; it < 60; it++) begin
      req_i = ($urandom_range(0, 4) == 0) ? '0 : N'($urandom_range(1, (1 << N) - 1));
      we_i = N'($urandom); sel_i = N'($urandom); lock_i = N'($urandom);
      for (int k = 0; k < N; k++) wdata_i[k*DW +: DW] = $urandom;
      rd_ctrl = $urandom; rd_fifo = $urandom;
      w = model_pick(req_i);
      if (w < 0) begin
        @(negedge Clk);
        n_tests++; if (gnt_o !== '0 || wr_o !== 1'b0) begin n_fail++; $display("FAIL rand_noreq iter %0d gnt %b wr %b exp 0 0", it, gnt_o, wr_o); end
        continue;
      end
      exp_we = we_i[w]; exp_sel = sel_i[w]; exp_wd = wdata_i[w*DW +: DW]; lk = lock_i[w];
      @(negedge Clk);
      n_tests++; if (gnt_o !== oh(w)) begin n_fail++; $display("FAIL rand_gnt iter %0d got %b exp %b", it, gnt_o, oh(w)); end
      n_tests++; if (wr_o !== exp_we) begin n_fail++; $display("FAIL rand_wr iter %0d got %b exp %b", it, wr_o, exp_we); end
      n_tests++; if (data_o !== exp_wd) begin n_fail++; $display("FAIL rand_data iter %0d got %h exp %h", it, data_o, exp_wd); end
      n_tests++; if (reg_sel_o !== exp_sel) begin n_fail++; $display("FAIL rand_sel iter %0d got %b exp %b", it, reg_sel_o, exp_sel); end
      n_tests++; if (ack_o !== '0) begin n_fail++; $display("FAIL rand_early_ack iter %0d got %b exp 0", it, ack_o); end
      we_i = N'($urandom); sel_i = N'($urandom);
      for (int k = 0; k < N; k++) wdata_i[k*DW +: DW] = $urandom;
      exp_rd = exp_we ? m_rdata : (exp_sel ? rd_fifo : rd_ctrl);
      @(negedge Clk);
      n_tests++; if (ack_o !== oh(w)) begin n_fail++; $display("FAIL rand_ack iter %0d got %b exp %b", it, ack_o, oh(w)); end
      n_tests++; if (wr_o !== 1'b0) begin n_fail++; $display("FAIL rand_done_wr iter %0d got %b exp 0", it, wr_o); end
      n_tests++; if (reg_sel_o !== exp_sel) begin n_fail++; $display("FAIL rand_done_sel iter %0d got %b exp %b", it, reg_sel_o, exp_sel); end
      n_tests++; if (rdata_o !== exp_rd) begin n_fail++; $display("FAIL rand_rdata iter %0d got %h exp %h", it, rdata_o, exp_rd); end
      m_rdata = exp_rd;
      model_done(w, lk);
      @(negedge Clk);
      n_tests++; if (gnt_o !== '0 || wr_o !== 1'b0) begin n_fail++; $display("FAIL rand_idle iter %0d gnt %b wr %b exp 0 0", it, gnt_o, wr_o); end
    end
    req_i = '0; lock_i = '0;
  endtask

`ifdef UART_ARB_LOCK_EN
  task automatic test_lock();
    int w;
    clear_inputs();
    do_reset();
    req_i = 4'b0011; lock_i = 4'b0001;
    for (int t = 0; t < 4; t++) begin
      w = model_pick(req_i);
      @(negedge Clk);
      n_tests++; if (gnt_o !== oh(w)) begin n_fail++; $display("FAIL lock_gnt txn %0d got %b exp %b", t, gnt_o, oh(w)); end
      @(negedge Clk);
      model_done(w, lock_i[w]);
      @(negedge Clk);
    end
    req_i = '0; lock_i = '0;
  endtask
`endif

  initial begin
    test_reset();
    test_single_write();
    test_read();
    test_contention();
    test_reset_mid_access();
    test_withdrawal();
    test_random();
`ifdef UART_ARB_LOCK_EN
    test_lock();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_host_arbiter.md
# uart_host_arbiter

Round-robin arbiter that shares the single UART agent register port (register select, write strobe, 32-bit write data, 32-bit read data) among several bus requesters. Each requester holds a request with its command until it receives a one-cycle acknowledge. The arbiter sequences exactly one register access per grant and returns the captured read data. It sits between the host-side requesters and the UART top-level agent port.

## Interface
Parameters:
- N_REQ, 4, number of requesters (legal 2..8)
- DW, 32, agent data width
- LOCK_MAX, 16, maximum consecutive locked transactions (used only with the lock feature)

Ports:
- Clk  in  1  clock, all logic on rising edge
- Rst_n  in  1  asynchronous active-low reset
- req_i  in  N_REQ  per-requester access request, level, held until ack
- we_i  in  N_REQ  per-requester write (1) / read (0)
- sel_i  in  N_REQ  per-requester register select (0 control regs, 1 FIFO)
- wdata_i  in  N_REQ*DW  per-requester write data, requester k in bits [k*DW +: DW]
- lock_i  in  N_REQ  per-requester bus lock request (present only with UART_ARB_LOCK_EN)
- gnt_o  out  N_REQ  one-hot grant, high during ACCESS and DONE
- ack_o  out  N_REQ  one-hot single-cycle completion pulse
- rdata_o  out  DW  captured read data, valid in the ack cycle, held until the next ack
- reg_sel_o  out  1  to agent register select
- wr_o  out  1  to agent write strobe
- data_o  out  DW  to agent write data
- data_i  in  DW  from agent read data (combinational on reg_sel_o)

## Operation
- States: IDLE, ACCESS, DONE.
- IDLE: if any req_i is high, pick the winner with round-robin from pointer ptr (search ptr, ptr+1, … mod N_REQ). Register the winner's sel and we, and its wdata into data_o, then go to ACCESS. If no req_i is high, stay in IDLE.
- ACCESS, one cycle: reg_sel_o = latched sel. wr_o = 1 only if latched we. data_o = latched wdata. Go to DONE.
- DONE, one cycle: reg_sel_o still held and wr_o = 0. If the access is a read, capture data_i into rdata_o. Pulse ack_o[winner]. Set ptr = winner+1 mod N_REQ. Go to IDLE.
- Requester inputs are sampled only in IDLE. Later changes before ack have no effect.
- A requester that drops req before being granted is simply skipped. It cannot drop req after grant, because the command is already latched.
- Write data is never truncated. For sel=1, only bits [7:0] are meaningful downstream.

## Timing
- Reset values: state IDLE, ptr 0, gnt_o 0, ack_o 0, rdata_o 0, reg_sel_o 0, wr_o 0, data_o 0.
- Latency when the arbiter is in IDLE and req rises before edge 0:
  - edge 0 → ACCESS, with gnt_o high and wr_o asserted.
  - edge 1 → DONE, with ack_o high.
  - edge 2 → IDLE.
- Throughput: one transaction per 3 cycles.
- wr_o is high for exactly one cycle per write. It is never high in IDLE or DONE.
- Simultaneous requests are resolved by the ptr order only. Every continuously requesting agent is served within N_REQ transactions.
- Reset mid-operation: all state clears immediately. No ack is issued for the aborted access, and wr_o drops asynchronously.
- A requester that holds req after its ack is treated as a new request. It competes again in the following IDLE cycle.

## Configuration
- UART_ARB_LOCK_EN defined:
  - The lock_i port exists.
  - In DONE, if lock_i[winner] is high and lock_cnt < LOCK_MAX-1, ptr is not advanced and lock_cnt increments. The same requester then wins the next IDLE if its req is high.
  - When lock_cnt reaches LOCK_MAX-1, or when lock is low, ptr advances and lock_cnt clears.
  - lock_cnt resets to 0.
- UART_ARB_LOCK_EN undefined: no lock_i port, no lock counter, and ptr always advances in DONE.

## Structure
- Shared package uart_arb_pkg holds:
  - the state enum (IDLE, ACCESS, DONE)
  - REG_SEL_CTRL=0 and REG_SEL_FIFO=1
  - the default N_REQ, DW and LOCK_MAX constants
- One sub-module, rr_pick: a combinational round-robin picker. Inputs are req vector and ptr. Outputs are one-hot winner, encoded index and any-valid.

## Test plan
- Single write, N_REQ=4: req_i=0001, we=1, sel=0, wdata=0x0000_00A5 → wr_o high for 1 cycle with data_o=0x A5 and reg_sel_o=0. ack_o=0001 arrives 2 cycles after sampling.
- Read: req_i[2], we=0, sel=1, data_i driven 0x0000_0042 → rdata_o=0x42 in the ack cycle, ack_o=0100, and wr_o never asserts.
- Contention: req_i=1111 held continuously from reset → grants in order 0,1,2,3,0 with one transaction every 3 cycles.
- Reset mid-ACCESS: assert Rst_n=0 during a write → wr_o drops immediately, no ack is issued, and after release the state is IDLE with ptr=0.
- Lock (UART_ARB_LOCK_EN, LOCK_MAX=3): req_i=0011 with lock_i[0]=1 → requester 0 gets 3 consecutive grants, then requester 1 is granted.
- Withdrawal: req_i[1] pulses for 1 cycle while requester 0 is in ACCESS → requester 1 is never granted and no ack_o[1] is issued.
